row_demux_1to4: RTL and testbench



---
 rtl/row_demux_1to4_pkg.sv | 24 ++
 rtl/row_demux_1to4_col_lane_counter.sv | 55 +++++
 rtl/row_demux_1to4.sv | 122 ++++++++++++
 tb/tb_row_demux_1to4.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/row_demux_1to4_pkg.sv
// Shared constants and types for the median-filter row buffers. The lane
// encoding here must match the read-side 4:1 row-select mux.
package row_demux_1to4_pkg;

    localparam int PIX_W     = 10;
    localparam int IMG_WIDTH = 640;
    localparam int COL_W     = 10;

    localparam logic [1:0] LANE_A = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;
    localparam logic [1:0] LANE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/row_demux_1to4_col_lane_counter.sv
// Column/lane position tracker for round-robin line buffers. It exposes the
// position of the current beat and a registered end-of-line pulse.
module col_lane_counter
    import row_demux_1to4_pkg::*;
#(
    parameter int IMG_W = IMG_WIDTH,
    parameter int CW    = COL_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart_i,
    input  logic          step_i,
    output logic [CW-1:0] col_o,
    output logic [1:0]    lane_o,
    output logic          wrap_o,
    output logic          line_done_o
);

    logic [CW-1:0] col_q, col_d;
    logic [1:0]    lane_q, lane_d;
    logic          line_done_q;

    // A restarting beat is itself placed at lane A, column 0.
    always_comb begin
        col_o  = restart_i ? '0 : col_q;
        lane_o = restart_i ? LANE_A : lane_q;
        wrap_o = (col_o == CW'(IMG_W - 1));
        col_d  = col_q;
        lane_d = lane_q;
        if (step_i) begin
            if (wrap_o) begin
                col_d  = '0;
                lane_d = lane_o + 2'd1;
            end else begin
                col_d  = col_o + 1'b1;
                lane_d = lane_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            lane_q      <= LANE_A;
            line_done_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            lane_q      <= lane_d;
            line_done_q <= step_i & wrap_o;
        end
    end

    assign line_done_o = line_done_q;

endmodule

// File: rtl/row_demux_1to4.sv
// Write-side row demux: steers a raster pixel stream into four line-buffer
// lanes round-robin by row and reports which lanes hold the last three rows.
module row_demux_1to4 #(
    parameter int WIDTH     = row_demux_1to4_pkg::PIX_W,
    parameter int IMG_WIDTH = row_demux_1to4_pkg::IMG_WIDTH,
    parameter int COL_W     = row_demux_1to4_pkg::COL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic             stall,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [3:0]       out_we,
    output logic [COL_W-1:0] wr_addr,
    output logic [1:0]       wr_lane,
    output logic [1:0]       read_base,
    output logic             line_done,
    output logic             rows_ready
);
    import row_demux_1to4_pkg::state_e;
    import row_demux_1to4_pkg::ST_IDLE;
    import row_demux_1to4_pkg::ST_FILL;
    import row_demux_1to4_pkg::ST_RUN;
    import row_demux_1to4_pkg::lane_onehot;

    state_e           state_q;
    logic [3:0]       out_we_q;
    logic [COL_W-1:0] wr_addr_q;
    logic [1:0]       wr_lane_q, read_base_q, lines_filled_q;
    logic             rows_ready_q;

    logic             accept, wr_en, wrap, reach_run;
    logic [COL_W-1:0] cur_col;
    logic [1:0]       cur_lane, lf_base, lf_inc, lines_filled_d;

    assign in_ready = ~rst & ~stall;
    assign accept   = in_valid & in_ready;
    // Outside a frame only a start-of-frame beat is stored.
    assign wr_en    = accept & (in_sof | (state_q != ST_IDLE));

    col_lane_counter #(
        .IMG_W (IMG_WIDTH),
        .CW    (COL_W)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .restart_i   (accept & in_sof),
        .step_i      (wr_en),
        .col_o       (cur_col),
        .lane_o      (cur_lane),
        .wrap_o      (wrap),
        .line_done_o (line_done)
    );

    always_comb begin
        lf_base        = in_sof ? 2'd0 : lines_filled_q;
        lf_inc         = (lf_base == 2'd3) ? 2'd3 : lf_base + 2'd1;
        lines_filled_d = wrap ? lf_inc : lf_base;
        reach_run      = wrap & (lf_inc == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            out_we_q       <= '0;
            wr_addr_q      <= '0;
            wr_lane_q      <= '0;
            read_base_q    <= '0;
            lines_filled_q <= '0;
            rows_ready_q   <= 1'b0;
        end else if (wr_en) begin
            out_we_q       <= lane_onehot(cur_lane);
            wr_addr_q      <= cur_col;
            wr_lane_q      <= cur_lane;
            read_base_q    <= cur_lane + 2'd1;
            lines_filled_q <= lines_filled_d;
            if (reach_run)
                rows_ready_q <= 1'b1;
            else if (in_sof)
                rows_ready_q <= 1'b0;
            if (in_eof)
                state_q <= ST_IDLE;
            else if (reach_run)
                state_q <= ST_RUN;
            else if (in_sof)
                state_q <= ST_FILL;
        end else begin
            out_we_q <= '0;
            // After an end-of-frame write the window stays valid for one cycle.
            if (state_q == ST_IDLE)
                rows_ready_q <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [WIDTH-1:0] data_q;
        always_ff @(posedge clk) begin
            if (rst)
                data_q <= '0;
            else
                data_q <= (wr_en && (cur_lane == 2'(gi))) ? in_data : '0;
        end
    end

    assign out_a      = g_lane[0].data_q;
    assign out_b      = g_lane[1].data_q;
    assign out_c      = g_lane[2].data_q;
    assign out_d      = g_lane[3].data_q;
    assign out_we     = out_we_q;
    assign wr_addr    = wr_addr_q;
    assign wr_lane    = wr_lane_q;
    assign read_base  = read_base_q;
    assign rows_ready = rows_ready_q;

endmodule

// File: tb/tb_row_demux_1to4.sv
// Bench for row_demux_1to4 with 4-pixel lines; the reference model derives
// lane, column and window state from the pixel index within the frame.
module tb_row_demux_1to4;
    localparam int W  = 10;
    localparam int IW = 4;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_sof, in_eof, stall;
    logic [W-1:0]  in_data;
    logic          in_ready, line_done, rows_ready;
    logic [W-1:0]  out_a, out_b, out_c, out_d;
    logic [3:0]    out_we;
    logic [CW-1:0] wr_addr;
    logic [1:0]    wr_lane, read_base;
    logic [W-1:0]  obs_dat [4];

    int checks = 0;
    int errors = 0;

    bit            in_frame;
    int            idx;
    logic [3:0]    e_we;
    logic [W-1:0]  e_dat [4];
    logic [CW-1:0] e_addr;
    logic [1:0]    e_lane, e_rb;
    logic          e_ld, e_rr;
    int            lane_cnt [4];

    always #5 clk = ~clk;

    row_demux_1to4 #(.WIDTH(W), .IMG_WIDTH(IW), .COL_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof), .stall(stall),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_we(out_we), .wr_addr(wr_addr), .wr_lane(wr_lane),
        .read_base(read_base), .line_done(line_done), .rows_ready(rows_ready)
    );

    assign obs_dat[0] = out_a;
    assign obs_dat[1] = out_b;
    assign obs_dat[2] = out_c;
    assign obs_dat[3] = out_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rpix();
        logic [31:0] r;
        r = $urandom;
        return r[W-1:0];
    endfunction

    // One clock of stimulus, model update and full output comparison.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic s,
                         input logic e, input logic st, input logic r);
        int col, lane;
        bit wr;
        rst = r; in_valid = v; in_data = d; in_sof = s; in_eof = e; stall = st;
        #1;
        chk("in_ready", in_ready, !r && !st);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) e_dat[i] = '0;
        if (r) begin
            in_frame = 0; idx = 0;
            e_we = '0; e_addr = '0; e_lane = '0; e_rb = '0; e_ld = 0; e_rr = 0;
        end else begin
            wr = v && !st && (s || in_frame);
            if (wr) begin
                if (s) idx = 0;
                col  = idx % IW;
                lane = (idx / IW) % 4;
                e_we = 4'(1 << lane);
                e_dat[lane] = d;
                e_addr = CW'(col);
                e_lane = 2'(lane);
                e_rb   = 2'((lane + 1) % 4);
                e_ld   = (col == IW - 1);
                e_rr   = ((idx + 1) / IW) >= 3;
                in_frame = !e;
                idx++;
            end else begin
                e_we = '0;
                e_ld = 0;
                if (!in_frame) e_rr = 0;
            end
        end
        for (int i = 0; i < 4; i++) lane_cnt[i] += int'(out_we[i]);
        $display("t=%0t rst=%0b v=%0b sof=%0b eof=%0b stall=%0b d=%03h | we=%b a=%03h b=%03h c=%03h d=%03h addr=%0d lane=%0d rb=%0d ld=%0b rr=%0b",
                 $time, r, v, s, e, st, d, out_we, out_a, out_b, out_c, out_d,
                 wr_addr, wr_lane, read_base, line_done, rows_ready);
        chk("out_we", out_we, e_we);
        for (int i = 0; i < 4; i++) chk($sformatf("out_lane%0d", i), obs_dat[i], e_dat[i]);
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_lane", wr_lane, e_lane);
        chk("read_base", read_base, e_rb);
        chk("line_done", line_done, e_ld);
        chk("rows_ready", rows_ready, e_rr);
    endtask

    initial begin
        in_frame = 0; idx = 0;
        e_we = '0; e_addr = '0; e_lane = '0; e_rb = '0; e_ld = 0; e_rr = 0;
        for (int i = 0; i < 4; i++) begin e_dat[i] = '0; lane_cnt[i] = 0; end

        // Reset, then idle.
        cycle(0, '0, 0, 0, 0, 1);
        cycle(0, '0, 0, 0, 0, 1);
        cycle(0, '0, 0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0, 0);

        // Beats before any start-of-frame are dropped, then the first line.
        for (int i = 0; i < 3; i++) cycle(1, 10'h3FF, 0, 0, 0, 0);
        cycle(1, 10'h001, 1, 0, 0, 0);
        chk("first_out_a", out_a, 10'h001);
        cycle(1, 10'h002, 0, 0, 0, 0);
        cycle(1, 10'h003, 0, 0, 0, 0);
        cycle(1, 10'h004, 0, 0, 0, 0);
        chk("first_line_done", line_done, 1'b1);
        chk("first_line_lane", wr_lane, 2'd0);
        chk("first_line_rb", read_base, 2'd1);

        // Fill all four lanes, reach RUN, then wrap back to lane a.
        for (int i = 0; i < 4; i++) lane_cnt[i] = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1, rpix(), i == 0, 0, 0, 0);
            if (i == 10) chk("rows_ready_pre", rows_ready, 1'b0);
            if (i == 11) chk("rows_ready_12th", rows_ready, 1'b1);
            if (i == 15) chk("rb_lane_d", read_base, 2'd0);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("lane%0d_writes", i), lane_cnt[i], 4);
        cycle(1, rpix(), 0, 0, 0, 0);
        chk("wrap_lane", wr_lane, 2'd0);
        chk("wrap_addr", wr_addr, 10'd0);

        // Stall mid-line at column 2.
        cycle(1, rpix(), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, rpix(), 0, 0, 1, 0);
            chk("stall_no_we", out_we, 4'b0000);
        end
        cycle(1, rpix(), 0, 0, 0, 0);
        chk("resume_addr", wr_addr, 10'd2);

        // Advance to lane 2 column 1, then restart the frame there.
        for (int k = 0; k < 40 && !(((idx % IW) == 1) && (((idx / IW) % 4) == 2)); k++)
            cycle(1, rpix(), 0, 0, 0, 0);
        chk("pre_sof_lane", wr_lane, 2'd2);
        chk("pre_sof_rr", rows_ready, 1'b1);
        cycle(1, rpix(), 1, 0, 0, 0);
        chk("midsof_we", out_we, 4'b0001);
        chk("midsof_rr", rows_ready, 1'b0);
        for (int i = 0; i < 13; i++) cycle(1, rpix(), 0, 0, 0, 0);
        cycle(1, rpix(), 0, 1, 0, 0);
        chk("eof_write", out_we != 4'b0000, 1'b1);
        cycle(1, rpix(), 0, 0, 0, 0);
        chk("eof_rr_clear", rows_ready, 1'b0);
        chk("eof_idle_drop", out_we, 4'b0000);

        // Single-pixel frame.
        cycle(1, rpix(), 1, 1, 0, 0);
        chk("single_we", out_we, 4'b0001);
        cycle(1, rpix(), 0, 0, 0, 0);

        // Reset at lane 1 column 2.
        for (int i = 0; i < 6; i++) cycle(1, rpix(), i == 0, 0, 0, 0);
        cycle(1, rpix(), 0, 0, 0, 1);
        chk("rst_we", out_we, 4'b0000);
        chk("rst_lane", wr_lane, 2'd0);
        cycle(1, 10'h155, 1, 0, 0, 0);
        chk("post_rst_a", out_a, 10'h155);
        chk("post_rst_addr", wr_addr, 10'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, rpix(), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 149) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
